// File: rtl/lvds_rx_phase_cal.sv
// lvds_rx_phase_cal: LVDS RX PLL reset/lock sequencer and dynamic-phase sweep picking the centre of the longest passing window.
// Optional LVDS_PHASE_CAL_LOCK_MON_EN: loss of lock while DONE triggers a full recalibration.
module lvds_rx_phase_cal #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int SETTLE_CYCLES = 64,
  parameter int SAMPLE_CYCLES = 256,
  parameter int MAX_RETRY = 3,
  parameter logic [3:0] DUTY_DEFAULT = 4'b1000,
  parameter logic [3:0] FDLY_DEFAULT = 4'b0000
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       start,
  input  logic       pll_lock,
  input  logic       word_ok,
  output logic       pll_reset,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  output logic [3:0] fdly,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_fail,
  output logic [3:0] best_phase,
  output logic [4:0] win_len
);
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, SETTLE, SAMPLE, NEXT, DONE, FAIL} state_t;
  localparam logic [3:0] RMAX = 4'(MAX_RETRY);
  state_t state, state_n;
  logic [16:0] cnt, cnt_lim;
  logic [1:0] lock_q;
  logic lock_s, cnt_end, pass, fail_evt, retry_last, better;
  logic [3:0] retry, run_start, best_start, run_start_n, fin_start, mid;
  logic [4:0] run_len, best_len, run_n, fin_len;
  assign lock_s = lock_q[1];
  assign pll_reset = state == PLL_RST;
  assign cal_done = state == DONE;
  assign cal_fail = state == FAIL;
  assign cal_busy = !(cal_done || cal_fail);
  assign dutyda = DUTY_DEFAULT;
  assign fdly = FDLY_DEFAULT;
  always_comb begin
    cnt_lim = state == PLL_RST ? 17'(PLL_RST_CYCLES - 1) :
              state == WAIT_LOCK ? 17'(LOCK_TIMEOUT - 1) :
              state == SETTLE ? 17'(SETTLE_CYCLES - 1) : 17'(SAMPLE_CYCLES - 1);
    cnt_end = cnt == cnt_lim;
    run_n = pass ? run_len + 5'd1 : 5'd0;
    run_start_n = (pass && run_len == 5'd0) ? psda : run_start;
    better = run_n > best_len;
    fin_len = better ? run_n : best_len;
    fin_start = better ? run_start_n : best_start;
    mid = fin_start + 4'((fin_len - 5'd1) >> 1);
    retry_last = (retry + 4'd1) == RMAX;
    fail_evt = 1'b0;
    state_n = state;
    case (state)
      PLL_RST:   if (cnt_end) state_n = WAIT_LOCK;
      WAIT_LOCK: if (lock_s) state_n = SETTLE; else if (cnt_end) fail_evt = 1'b1;
      SETTLE:    if (cnt_end) state_n = SAMPLE;
      SAMPLE:    if (cnt_end) state_n = NEXT;
      NEXT:      state_n = psda != 4'hf ? SETTLE : fin_len == 5'd0 ? FAIL : DONE;
      DONE: begin
        if (start) state_n = PLL_RST;
`ifdef LVDS_PHASE_CAL_LOCK_MON_EN
        else if (!lock_s) state_n = PLL_RST;
`endif
      end
      FAIL:      if (start) state_n = PLL_RST;
      default:   state_n = PLL_RST;
    endcase
    // losing lock mid-sweep invalidates every phase result gathered so far
    if (!lock_s && (state == SETTLE || state == SAMPLE || state == NEXT)) fail_evt = 1'b1;
    if (fail_evt) state_n = retry_last ? FAIL : PLL_RST;
  end
  always_ff @(posedge clkin or posedge reset)
    if (reset) state <= PLL_RST;
    else state <= state_n;
  always_ff @(posedge clkin or posedge reset)
    if (reset) begin
      lock_q <= 2'b00;
      cnt <= '0;
      pass <= 1'b1;
      retry <= '0;
      psda <= '0;
      run_len <= '0;
      run_start <= '0;
      best_len <= '0;
      best_start <= '0;
      best_phase <= '0;
      win_len <= '0;
    end else begin
      lock_q <= {lock_q[0], pll_lock};
      cnt <= state_n != state ? 17'd0 : cnt + 17'd1;
      pass <= state == SAMPLE ? pass & word_ok : 1'b1;
      retry <= (state_n == DONE || (start && !cal_busy)) ? 4'd0 : fail_evt ? retry + 4'd1 : retry;
      if (state == NEXT) begin
        run_len <= run_n;
        run_start <= run_start_n;
        best_len <= fin_len;
        best_start <= fin_start;
      end
      if (state_n == PLL_RST) begin
        run_len <= '0;
        run_start <= '0;
        best_len <= '0;
        best_start <= '0;
      end
      psda <= (state_n == PLL_RST || state_n == FAIL) ? 4'd0 :
              (state == NEXT && state_n == DONE) ? mid :
              (state == NEXT && state_n == SETTLE) ? psda + 4'd1 : psda;
      best_phase <= state_n == FAIL ? 4'd0 : (state == NEXT && state_n == DONE) ? mid : best_phase;
      win_len <= state_n == FAIL ? 5'd0 : (state == NEXT && state_n == DONE) ? fin_len : win_len;
    end
endmodule

// File: tb/tb_lvds_rx_phase_cal.sv
// tb_lvds_rx_phase_cal: directed bench with a PLL lock model and a per-phase word_ok mask.
module tb_lvds_rx_phase_cal;
  logic clkin = 1'b0, reset = 1'b1, start = 1'b0, lock_en = 1'b1, drop = 1'b0;
  logic [15:0] mask = 16'h03E0;
  logic pll_lock, word_ok, pll_reset, cal_busy, cal_done, cal_fail, prev_rst = 1'b0;
  logic [3:0] psda, dutyda, fdly, best_phase;
  logic [4:0] win_len;
  int lock_ctr = 0, cyc = 0, pulses = 0, checks = 0, errors = 0, n = 0, base = 0;

  lvds_rx_phase_cal #(.PLL_RST_CYCLES(4), .LOCK_TIMEOUT(100), .SETTLE_CYCLES(8),
                      .SAMPLE_CYCLES(16), .MAX_RETRY(3)) dut (
    .clkin(clkin), .reset(reset), .start(start), .pll_lock(pll_lock), .word_ok(word_ok),
    .pll_reset(pll_reset), .psda(psda), .dutyda(dutyda), .fdly(fdly), .cal_busy(cal_busy),
    .cal_done(cal_done), .cal_fail(cal_fail), .best_phase(best_phase), .win_len(win_len));

  always #5 clkin = ~clkin;

  // PLL locks 10 cycles after its reset is released
  always @(posedge clkin) begin
    lock_ctr <= pll_reset ? 0 : (lock_ctr < 1000 ? lock_ctr + 1 : lock_ctr);
    cyc <= cyc + 1;
  end
  assign pll_lock = lock_en && !pll_reset && lock_ctr >= 10;
  assign word_ok = mask[psda] && !(drop && (cyc % 12) == 0);

  always @(negedge clkin) begin
    if (pll_reset && !prev_rst) pulses <= pulses + 1;
    prev_rst <= pll_reset;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_end(input int lim);
    n = 0;
    while (!(cal_done || cal_fail) && n < lim) begin
      @(negedge clkin);
      n++;
    end
    check("end_timeout", 32'(n < lim), 1);
  endtask

  task automatic wait_psda(input logic [3:0] v, input int lim);
    n = 0;
    while (psda !== v && n < lim) begin
      @(negedge clkin);
      n++;
    end
    check("psda_timeout", 32'(n < lim), 1);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clkin);
    start = 1'b0;
    check("busy_after_start", 32'(cal_busy), 1);
  endtask

  task automatic check_result(input string tag, input logic [3:0] ph, input logic [4:0] len);
    check({tag, "_done"}, 32'(cal_done), 1);
    check({tag, "_phase"}, 32'(best_phase), 32'(ph));
    check({tag, "_len"}, 32'(win_len), 32'(len));
    check({tag, "_psda"}, 32'(psda), 32'(ph));
  endtask

  initial begin
    @(negedge clkin);
    check("rst_pll_reset", 32'(pll_reset), 1);
    check("rst_psda", 32'(psda), 0);
    check("rst_dutyda", 32'(dutyda), 32'h8);
    check("rst_fdly", 32'(fdly), 0);
    check("rst_flags", 32'({cal_busy, cal_done, cal_fail}), 32'b100);
    check("rst_result", 32'({best_phase, win_len}), 0);
    reset = 1'b0;
    wait_end(2000);
    check_result("win5_9", 4'd7, 5'd16 - 5'd11);
    check("win5_9_busy", 32'(cal_busy), 0);
    mask = 16'h180C;
    pulse_start();
    wait_end(2000);
    check_result("tie", 4'd2, 5'd2);
    mask = 16'hFFFF;
    pulse_start();
    wait_end(2000);
    check_result("all_pass", 4'd7, 5'd16);
    drop = 1'b1;
    pulse_start();
    wait_end(2000);
    check("drop_fail", 32'(cal_fail), 1);
    check("drop_psda", 32'(psda), 0);
    check("drop_result", 32'({best_phase, win_len}), 0);
    drop = 1'b0;
    mask = 16'h03E0;
    lock_en = 1'b0;
    base = pulses;
    pulse_start();
    wait_end(1000);
    check("nolock_fail", 32'(cal_fail), 1);
    check("nolock_pulses", 32'(pulses - base), 3);
    check("nolock_time", 32'(n >= 310 && n <= 314), 1);
    check("nolock_pll_reset", 32'(pll_reset), 0);
    lock_en = 1'b1;
    pulse_start();
    wait_psda(4'd9, 1000);
    repeat (12) @(negedge clkin);
    lock_en = 1'b0;
    base = pulses;
    n = 0;
    while (!pll_reset && n < 20) begin
      @(negedge clkin);
      n++;
    end
    check("lockdrop_pll_reset", 32'(pll_reset), 1);
    check("lockdrop_psda", 32'(psda), 0);
    lock_en = 1'b1;
    wait_end(2000);
    check_result("lockdrop", 4'd7, 5'd5);
    lock_en = 1'b0;
    repeat (4) @(negedge clkin);
    lock_en = 1'b1;
`ifdef LVDS_PHASE_CAL_LOCK_MON_EN
    check("mon_recal_busy", 32'(cal_busy), 1);
    wait_end(2000);
    check_result("mon_recal", 4'd7, 5'd5);
`else
    check("mon_off_done", 32'({cal_done, cal_busy}), 32'b10);
    check("mon_off_psda", 32'(psda), 7);
`endif
    pulse_start();
    wait_psda(4'd3, 1000);
    repeat (12) @(negedge clkin);
    #2 reset = 1'b1;
    #1;
    check("async_pll_reset", 32'(pll_reset), 1);
    check("async_psda", 32'(psda), 0);
    check("async_flags", 32'({cal_busy, cal_done, cal_fail}), 32'b100);
    check("async_result", 32'({best_phase, win_len}), 0);
    @(negedge clkin);
    reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
